// File: rtl/fifo_write_serializer.sv
// Purpose : width down-converter, one FETCH_WIDTH-element packed word in, one element per wclk out to async_fifo1.
// Latency : word accepted at edge N presents element 0 with fifo_winc=1 in cycle N+1 (FIFO not full).
// Backpr. : fifo_wfull freezes idx/hold_q and drops fifo_winc; in_ready only opens in IDLE or on the last write.
//
// Optional feature macro: FWS_STALL_CNT_EN adds the saturating stall_cnt output and its counter.
// Element i of a packed word is emitted i-th, so the read-side aggregator re-packs it into slice i.
// Reset is synchronous active-low (wrst_n); a reset mid-word discards the unsent elements.

module fifo_write_serializer #(
   parameter int DATA_WIDTH  = 11,
   parameter int FETCH_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                              wclk,
   input  logic                              wrst_n,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [DATA_WIDTH-1:0]             fifo_wdata,
   output logic                              fifo_winc,
   input  logic                              fifo_wfull
`ifdef FWS_STALL_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]              stall_cnt
`endif
);

   localparam int IDX_W = $clog2(FETCH_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FETCH_WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Held word viewed as an array of elements so idx selects a slice directly.
   typedef logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] word_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   word_t            hold_q,  hold_d;

   logic             last_wr;
   logic             accept;

   // Handshake decode; wrst_n gating keeps both strobes low for the whole reset cycle,
   // including the cycle before the first reset edge when state_q is still unknown.
   always_comb begin
      fifo_winc = wrst_n && (state_q == SEND) && !fifo_wfull;
      last_wr   = fifo_winc && (idx_q == IDX_LAST);
      in_ready  = wrst_n && ((state_q == IDLE) || last_wr);
      accept    = in_valid && in_ready;
   end

   // Current element straight from registers, so it cannot move while fifo_winc is low.
   always_comb begin
      fifo_wdata = hold_q[idx_q];
   end

   // Next-state: load on accept, advance idx on each write, reload on last write + accept.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SEND;
               idx_d   = '0;
               hold_d  = word_t'(in_data);
            end
         end
         SEND: begin
            if (fifo_winc) begin
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  if (accept) begin
                     state_d = SEND;
                     hold_d  = word_t'(in_data);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any partially sent word.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

`ifdef FWS_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;

   // Count cycles where a held element is blocked by a full FIFO; saturates, clears only on reset.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         stall_cnt_q <= '0;
      end else if ((state_q == SEND) && fifo_wfull && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_serializer.sv
// Bench for fifo_write_serializer: queue-of-pending-elements reference model, per-cycle compare,
// plus directed scenarios (reset, single word, back-to-back, stall, reset mid-word, random).
// Build with or without FWS_STALL_CNT_EN; stall_cnt checks follow the macro.

module tb_fifo_write_serializer;

   localparam int DW = 11;
   localparam int FW = 4;
   localparam int CW = 16;

   logic              wclk = 1'b0;
   logic              wrst_n = 1'b0;
   logic [FW*DW-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DW-1:0]     fifo_wdata;
   logic              fifo_winc;
   logic              fifo_wfull = 1'b0;
`ifdef FWS_STALL_CNT_EN
   logic [CW-1:0]     stall_cnt;
`endif

   always #5 wclk = ~wclk;

   fifo_write_serializer #(
      .DATA_WIDTH (DW),
      .FETCH_WIDTH(FW),
      .CNT_WIDTH  (CW)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fifo_wdata(fifo_wdata),
      .fifo_winc (fifo_winc),
      .fifo_wfull(fifo_wfull)
`ifdef FWS_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;

   // Reference model: elements still owed to the FIFO, oldest first.
   int q[$];
   int stall_m  = 0;
   bit m_accept = 1'b0;
   bit chk_en   = 1'b0;

   // Writes observed on the FIFO port, with the cycle number they occurred in.
   int wr_log[$];
   int wr_stamp[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_winc();
      return wrst_n && (q.size() > 0) && !fifo_wfull;
   endfunction

   // Ready when nothing is owed, or the final owed element goes out this cycle.
   function automatic bit exp_ready();
      return wrst_n && ((q.size() == 0) || ((q.size() == 1) && !fifo_wfull));
   endfunction

   function automatic logic [FW*DW-1:0] pack(input int base);
      logic [FW*DW-1:0] r;
      r = '0;
      for (int i = 0; i < FW; i++) r[i*DW +: DW] = DW'(base + i);
      return r;
   endfunction

   // Advance the model at each edge from the inputs it sees there.
   always @(posedge wclk) begin : model
      bit w;
      bit a;
      cyc_n++;
      if (!wrst_n) begin
         q.delete();
         stall_m  = 0;
         m_accept = 1'b0;
      end else begin
         w = exp_winc();
         a = in_valid && exp_ready();
         if ((q.size() > 0) && fifo_wfull && (stall_m < (1 << CW) - 1)) stall_m++;
         if (w) void'(q.pop_front());
         if (a) for (int i = 0; i < FW; i++) q.push_back(int'(in_data[i*DW +: DW]));
         m_accept = a;
      end
      chk_en = 1'b1;
   end

   // Compare DUT against the model mid-cycle.
   always @(negedge wclk) begin : compare
      if (chk_en) begin
         check("in_ready", 32'(in_ready), 32'(exp_ready()));
         check("fifo_winc", 32'(fifo_winc), 32'(exp_winc()));
         if (wrst_n && (q.size() > 0)) check("fifo_wdata", 32'(fifo_wdata), q[0]);
`ifdef FWS_STALL_CNT_EN
         check("stall_cnt", 32'(stall_cnt), stall_m);
`endif
         if (fifo_winc === 1'b1) begin
            wr_log.push_back(int'(fifo_wdata));
            wr_stamp.push_back(cyc_n);
         end
      end
   end

   task automatic cyc();
      @(posedge wclk);
      #1;
   endtask

   task automatic clear_log();
      wr_log.delete();
      wr_stamp.delete();
   endtask

   initial begin : stim
      int k;
      int acc_c;
      int bad;
      int guard;

      // 1: reset held with in_valid high
      wrst_n   = 1'b0;
      in_valid = 1'b1;
      in_data  = pack(0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_fifo_winc", 32'(fifo_winc), 0);
      end
      wrst_n   = 1'b1;
      in_valid = 1'b0;
      cyc();

      // 2: single word 0,1,2,3
      clear_log();
      in_data  = pack(0);
      in_valid = 1'b1;
      cyc();
      acc_c    = cyc_n;
      in_valid = 1'b0;
      repeat (6) cyc();
      check("single_count", wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) check("single_data", wr_log[i], i);
      if (wr_log.size() == 4) begin
         check("single_latency", wr_stamp[0], acc_c);
         check("single_span", wr_stamp[3] - wr_stamp[0], 3);
      end
      check("single_idle_ready", 32'(in_ready), 1);

      // 3: eight words back to back, no bubbles
      clear_log();
      k        = 0;
      guard    = 0;
      in_data  = pack(0);
      in_valid = 1'b1;
      while (k < 8 && guard < 100) begin
         cyc();
         guard++;
         if (m_accept) begin
            k++;
            if (k < 8) in_data = pack(4 * k);
            else       in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("b2b_accepts", k, 8);
      repeat (8) cyc();
      check("b2b_count", wr_log.size(), 32);
      bad = 0;
      for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != i) bad++;
      check("b2b_data_bad", bad, 0);
      if (wr_log.size() == 32) check("b2b_span", wr_stamp[31] - wr_stamp[0], 31);

      // 4: stall for 3 cycles after element 1
      clear_log();
      in_data  = pack(40);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      fifo_wfull = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge wclk);
         check("stall_hold_data", 32'(fifo_wdata), 42);
         check("stall_winc_low", 32'(fifo_winc), 0);
         check("stall_ready_low", 32'(in_ready), 0);
         cyc();
      end
      fifo_wfull = 1'b0;
      @(negedge wclk);
      check("stall_resume_winc", 32'(fifo_winc), 1);
      check("stall_resume_data", 32'(fifo_wdata), 42);
`ifdef FWS_STALL_CNT_EN
      check("stall_cnt_lit", 32'(stall_cnt), 3);
`endif
      repeat (5) cyc();
      check("stall_count", wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) check("stall_data", wr_log[i], 40 + i);

      // 5: reset after two elements; old elements 2,3 are dropped
      clear_log();
      in_data  = pack(100);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      wrst_n = 1'b0;
      cyc();
      cyc();
      wrst_n   = 1'b1;
      in_data  = pack(200);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (6) cyc();
      check("rstmid_count", wr_log.size(), 6);
      if (wr_log.size() == 6) begin
         check("rstmid_d0", wr_log[0], 100);
         check("rstmid_d1", wr_log[1], 101);
         for (int i = 0; i < 4; i++) check("rstmid_new", wr_log[2 + i], 200 + i);
      end

      // 6: random valid / wfull, stream must be 0,1,2,... exactly
      wrst_n = 1'b0;
      cyc();
      wrst_n = 1'b1;
      clear_log();
      k       = 0;
      in_data = pack(0);
      for (int n = 0; n < 2000; n++) begin
         in_valid   = 1'($urandom % 2);
         fifo_wfull = 1'($urandom % 2);
         cyc();
         if (m_accept) begin
            k++;
            in_data = pack(4 * k);
         end
      end
      in_valid   = 1'b0;
      fifo_wfull = 1'b0;
      repeat (10) cyc();
      check("rand_count", wr_log.size(), 4 * k);
      bad = 0;
      for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != (i % (1 << DW))) bad++;
      check("rand_stream_bad", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
